// File: rtl/odd_parity_pkg.sv
// Shared odd-parity definitions: FSM state type, default widths, frame length
// and the odd-parity function used by both the generator and the receiver.
package odd_parity_pkg;

   localparam int DATA_W_DEF = 8;
   // start + data + parity + stop
   localparam int FRAME_LEN  = DATA_W_DEF + 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_e;

   // Odd parity bit: makes data plus parity carry an odd number of ones.
   function automatic logic odd_parity(input logic [DATA_W_DEF-1:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/odd_parity_rx_if.sv
// Serial-in / byte-out bundle of the odd-parity receiver.
// err_count exists only when ODD_PARITY_RX_ERR_COUNT_EN is defined.
interface odd_parity_rx_if #(
   parameter int DATA_W = 8
`ifdef ODD_PARITY_RX_ERR_COUNT_EN
   , parameter int CNT_W = 8
`endif
);
   logic              bit_en;
   logic              din;
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic              busy;
`ifdef ODD_PARITY_RX_ERR_COUNT_EN
   logic [CNT_W-1:0]  err_count;

   modport master (output bit_en, din,
                   input  data, data_valid, parity_err, frame_err, busy, err_count);
   modport slave  (input  bit_en, din,
                   output data, data_valid, parity_err, frame_err, busy, err_count);
`else
   modport master (output bit_en, din,
                   input  data, data_valid, parity_err, frame_err, busy);
   modport slave  (input  bit_en, din,
                   output data, data_valid, parity_err, frame_err, busy);
`endif
endinterface

// File: rtl/odd_parity_shift_in.sv
// Deserializer datapath: LSB-first shift register plus running XOR of every
// bit fed in. clr starts a new frame, shift takes a data bit, acc folds a
// bit into the XOR only (used for the parity bit).
module odd_parity_shift_in #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              shift_i,
   input  logic              acc_i,
   input  logic              din_i,
   output logic [DATA_W-1:0] data_o,
   output logic              acc_o
);

   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              acc_q, acc_d;

   // Next-state: right shift so the first bit ends up in position 0.
   always_comb begin
      shreg_d = shreg_q;
      acc_d   = acc_q;
      if (clr_i) begin
         shreg_d = '0;
         acc_d   = 1'b0;
      end else begin
         if (shift_i) shreg_d = {din_i, shreg_q[DATA_W-1:1]};
         if (shift_i || acc_i) acc_d = acc_q ^ din_i;
      end
   end

   // Register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         acc_q   <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         acc_q   <= acc_d;
      end
   end

   assign data_o = shreg_q;
   assign acc_o  = acc_q;

endmodule

// File: rtl/odd_parity_rx.sv
// Odd-parity serial frame receiver: start, DATA_W data bits (LSB first),
// parity, stop. Advances only on bit_en strobes. Delivers the byte with a
// one-cycle data_valid and held parity/framing error flags.
// Optional saturating error counter: define ODD_PARITY_RX_ERR_COUNT_EN.
module odd_parity_rx
   import odd_parity_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
`ifdef ODD_PARITY_RX_ERR_COUNT_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic          clk,
   input  logic          rst,
   odd_parity_rx_if.slave bus
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;

   logic              clr, shift, acc_en;
   logic [DATA_W-1:0] shreg;
   logic              acc;

   odd_parity_shift_in #(.DATA_W(DATA_W)) u_shift (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr),
      .shift_i (shift),
      .acc_i   (acc_en),
      .din_i   (bus.din),
      .data_o  (shreg),
      .acc_o   (acc)
   );

   // Frame FSM; everything holds on cycles without a strobe.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      clr       = 1'b0;
      shift     = 1'b0;
      acc_en    = 1'b0;
      if (bus.bit_en) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!bus.din) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
                  clr       = 1'b1;
               end
            end
            ST_DATA: begin
               shift     = 1'b1;
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (bit_cnt_q == CW'(DATA_W - 1)) begin
                  state_d   = ST_PARITY;
                  bit_cnt_d = '0;
               end
            end
            ST_PARITY: begin
               acc_en  = 1'b1;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               // acc now holds XOR of data+parity: 1 means odd, i.e. good.
               data_d  = shreg;
               perr_d  = ~acc;
               ferr_d  = ~bus.din;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign bus.data       = data_q;
   assign bus.data_valid = valid_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.busy       = (state_q != ST_IDLE);

`ifdef ODD_PARITY_RX_ERR_COUNT_EN
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Count errored frames in step with the data_valid pulse; stick at max.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (valid_d && (perr_d || ferr_d) && (err_cnt_q != {CNT_W{1'b1}}))
         err_cnt_d = err_cnt_q + CNT_W'(1);
   end

   // Error counter register; cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_odd_parity_rx.sv
// Self-checking bench for odd_parity_rx: directed frame table, hand-written
// corner sequences and random traffic, all checked every cycle against a
// frame-level reference model. Honours ODD_PARITY_RX_ERR_COUNT_EN.
module tb_odd_parity_rx;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

`ifdef ODD_PARITY_RX_ERR_COUNT_EN
   odd_parity_rx_if #(.DATA_W(W), .CNT_W(8)) bus ();
   odd_parity_rx #(.DATA_W(W), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
   odd_parity_rx_if #(.DATA_W(W)) bus ();
   odd_parity_rx #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int cyc_n  = 0;
   int last_pulse = 0;
   int pulse_gap  = 0;

   // Reference model: collect strobed bits of a frame, decode at 11 bits.
   bit         fq[$];
   logic [7:0] m_data  = 8'h00;
   bit         m_valid = 1'b0;
   bit         m_perr  = 1'b0;
   bit         m_ferr  = 1'b0;
   bit         m_busy  = 1'b0;
   int         m_cnt   = 0;

   typedef struct {
      logic [7:0] d;
      bit         p;
      bit         stop;
      int         stall;
      logic [7:0] exp_data;
      bit         exp_perr;
      bit         exp_ferr;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   task automatic model(input bit r, input bit en, input bit d);
      int ones;
      m_valid = 1'b0;
      if (r) begin
         fq.delete();
         m_data = 8'h00;
         m_perr = 1'b0;
         m_ferr = 1'b0;
         m_cnt  = 0;
      end else if (en) begin
         if (fq.size() != 0 || d == 1'b0) fq.push_back(d);
         if (fq.size() == 11) begin
            for (int i = 0; i < 8; i++) m_data[i] = fq[i + 1];
            ones    = $countones(m_data) + int'(fq[9]);
            m_perr  = (ones % 2 == 0);
            m_ferr  = (fq[10] == 1'b0);
            m_valid = 1'b1;
            if ((m_perr || m_ferr) && m_cnt < 255) m_cnt++;
            fq.delete();
         end
      end
      m_busy = (fq.size() != 0);
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge.
   task automatic cyc(input bit r, input bit en, input bit d);
      rst        = r;
      bus.bit_en = en;
      bus.din    = d;
      @(posedge clk);
      model(r, en, d);
      cyc_n++;
      @(negedge clk);
      chk("data_valid", {31'd0, bus.data_valid}, {31'd0, m_valid});
      chk("busy",       {31'd0, bus.busy},       {31'd0, m_busy});
      chk("data",       {24'd0, bus.data},       {24'd0, m_data});
      chk("parity_err", {31'd0, bus.parity_err}, {31'd0, m_perr});
      chk("frame_err",  {31'd0, bus.frame_err},  {31'd0, m_ferr});
`ifdef ODD_PARITY_RX_ERR_COUNT_EN
      chk("err_count",  {24'd0, bus.err_count},  m_cnt);
`endif
      if (bus.data_valid === 1'b1) begin
         pulse_gap  = cyc_n - last_pulse;
         last_pulse = cyc_n;
      end
   endtask

   task automatic send(input logic [7:0] d, input bit p, input bit stop, input int stall);
      bit fr[11];
      fr[0] = 1'b0;
      for (int i = 0; i < 8; i++) fr[i + 1] = d[i];
      fr[9]  = p;
      fr[10] = stop;
      for (int i = 0; i < 11; i++) begin
         cyc(1'b0, 1'b1, fr[i]);
         if (i != 10) repeat (stall) cyc(1'b0, 1'b0, 1'($urandom % 2));
      end
   endtask

   initial begin
      //         d      p     stop  stall exp_data perr  ferr
      tbl[0] = '{8'h01, 1'b0, 1'b1, 0,    8'h01,   1'b0, 1'b0};
      tbl[1] = '{8'h03, 1'b0, 1'b1, 0,    8'h03,   1'b1, 1'b0};
      tbl[2] = '{8'hFF, 1'b1, 1'b0, 0,    8'hFF,   1'b0, 1'b1};
      tbl[3] = '{8'hA5, 1'b1, 1'b1, 3,    8'hA5,   1'b0, 1'b0};
      tbl[4] = '{8'h00, 1'b1, 1'b1, 0,    8'h00,   1'b0, 1'b0};
      tbl[5] = '{8'h7F, 1'b0, 1'b1, 0,    8'h7F,   1'b0, 1'b0};

      rst = 1'b1; bus.bit_en = 1'b0; bus.din = 1'b1;
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b0);
      chk("rst_data",  {24'd0, bus.data}, 32'd0);
      chk("rst_valid", {31'd0, bus.data_valid}, 32'd0);
      chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("rst_perr",  {31'd0, bus.parity_err}, 32'd0);
      chk("rst_ferr",  {31'd0, bus.frame_err}, 32'd0);
      cyc(1'b0, 1'b1, 1'b1);

      // Directed frames, sent back to back after the idle strobe above.
      for (int i = 0; i < 6; i++) begin
         send(tbl[i].d, tbl[i].p, tbl[i].stop, tbl[i].stall);
         chk($sformatf("tbl%0d_valid", i), {31'd0, bus.data_valid}, 32'd1);
         chk($sformatf("tbl%0d_data", i),  {24'd0, bus.data}, {24'd0, tbl[i].exp_data});
         chk($sformatf("tbl%0d_perr", i),  {31'd0, bus.parity_err}, {31'd0, tbl[i].exp_perr});
         chk($sformatf("tbl%0d_ferr", i),  {31'd0, bus.frame_err}, {31'd0, tbl[i].exp_ferr});
         if (i == 5) chk("b2b_gap", pulse_gap, 32'd11);
`ifdef ODD_PARITY_RX_ERR_COUNT_EN
         if (i == 1) chk("errcnt_after_perr", {24'd0, bus.err_count}, 32'd1);
`endif
      end

      // Pulse is one cycle even with the strobe held high.
      cyc(1'b0, 1'b1, 1'b1);
      chk("pulse_one_cycle", {31'd0, bus.data_valid}, 32'd0);
      chk("idle_not_busy",   {31'd0, bus.busy}, 32'd0);

      // Reset after 4th data bit, with a start-like strobe in the reset cycle.
      cyc(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'(i % 2));
      chk("mid_busy", {31'd0, bus.busy}, 32'd1);
      cyc(1'b1, 1'b1, 1'b0);
      chk("abort_busy",  {31'd0, bus.busy}, 32'd0);
      chk("abort_data",  {24'd0, bus.data}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b1, 1'b1);
         chk("abort_no_pulse", {31'd0, bus.data_valid}, 32'd0);
      end
      send(8'h3C, 1'b1, 1'b1, 0);
      chk("after_rst_valid", {31'd0, bus.data_valid}, 32'd1);
      chk("after_rst_data",  {24'd0, bus.data}, 32'h3C);
      chk("after_rst_perr",  {31'd0, bus.parity_err}, 32'd0);

      // Random well-formed-ish frames with random stalls and idle gaps.
      for (int n = 0; n < 40; n++) begin
         send(8'($urandom), 1'($urandom % 2), ($urandom % 4) != 0, int'($urandom % 3));
         repeat ($urandom % 3) cyc(1'b0, 1'($urandom % 2), 1'b1);
      end

      // Fully random line activity with rare resets.
      for (int n = 0; n < 1500; n++)
         cyc(($urandom % 200) == 0, 1'($urandom % 2), 1'($urandom % 2));

`ifdef ODD_PARITY_RX_ERR_COUNT_EN
      // Saturation of the error counter.
      cyc(1'b1, 1'b0, 1'b1);
      for (int n = 0; n < 260; n++) send(8'h00, 1'b1, 1'b0, 0);
      chk("errcnt_sat", {24'd0, bus.err_count}, 32'd255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
